imem_loader: RTL

Program loader for the single-cycle processor's 128 x 16 instruction memory. It accepts a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. Each word is written into the memory's write port at consecutive addresses from 0. All addresses not loaded are padded with the halt word. While loading, it holds the processor in stall via `cpu_hold`.

---
 rtl/imem_loader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader for a 128 x 16 instruction memory. It assembles
// big-endian words, pads unloaded addresses with HALT_WORD and holds the CPU while busy.
module imem_loader #(
    parameter int          ADDR_W    = 7,
    parameter int          DEPTH     = 128,
    parameter logic [15:0] HALT_WORD = 16'hF000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [15:0]       wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [7:0]        word_count
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_HI   = 3'd2;
    localparam logic [2:0] S_LO   = 3'd3;
    localparam logic [2:0] S_FILL = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    localparam logic [8:0]        DEPTH_V   = 9'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wc_q, wc_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        n_q, n_d;
    logic              accept;
    logic [7:0]        wc_inc;
    logic              hdr_ok;

    assign in_ready   = (state_q == S_HDR) || (state_q == S_HI) || (state_q == S_LO);
    assign cpu_hold   = (state_q != S_IDLE);
    assign done       = (state_q == S_FIN);
    assign err        = err_q;
    assign word_count = wc_q;
    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;

    assign accept = in_valid && in_ready;
    assign wc_inc = wc_q + 8'd1;
    assign hdr_ok = (in_data != 8'd0) && ({1'b0, in_data} <= DEPTH_V);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wc_d    = wc_q;
        err_d   = err_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        hi_d    = hi_q;
        n_d     = n_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    wc_d    = 8'd0;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (accept) begin
                    addr_d = '0;
                    // A bad count still leaves the memory fully defined: pad all of it.
                    if (hdr_ok) begin
                        n_d     = in_data;
                        state_d = S_HI;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_FILL;
                    end
                end
            end
            S_HI: begin
                if (accept) begin
                    hi_d    = in_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = {hi_q, in_data};
                    addr_d  = addr_q + ADDR_W'(1);
                    wc_d    = wc_inc;
                    if (wc_inc == n_q) begin
                        state_d = ({1'b0, n_q} == DEPTH_V) ? S_FIN : S_FILL;
                    end else begin
                        state_d = S_HI;
                    end
                end
            end
            S_FILL: begin
                we_d    = 1'b1;
                waddr_d = addr_q;
                wdata_d = HALT_WORD;
                addr_d  = addr_q + ADDR_W'(1);
                if (addr_q == LAST_ADDR) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wc_q    <= 8'd0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 16'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wc_q    <= wc_d;
            err_q   <= err_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Pure datapath holding registers; they are always written before being read.
    always_ff @(posedge clk) begin
        hi_q <= hi_d;
        n_q  <= n_d;
    end

endmodule
